rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (rg_wrt_en / rg_wrt_dest / rg_wrt_data) between two requesters:
  - WB: in-order pipeline writeback.
  - MD: multi-cycle mul/div unit.
- Keeps a per-register pending scoreboard for MD destinations; decode stalls on hazards using it.
- Sits between the writeback stage / MD unit and RegFile; decode hazard logic consumes its busy flags.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDRESS_WIDTH, 5, register address width.
- NUM_REGS, 32, number of registers tracked by the scoreboard.
- STARVE_LIMIT, 4, consecutive stalled MD cycles before MD gains priority (must be >= 1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- wb_valid  in  1  WB write request.
- wb_dest  in  ADDRESS_WIDTH  WB destination register.
- wb_data  in  DATA_WIDTH  WB write data.
- wb_ready  out  1  WB request accepted this cycle (combinational).
- md_valid  in  1  MD write request.
- md_dest  in  ADDRESS_WIDTH  MD destination register.
- md_data  in  DATA_WIDTH  MD write data.
- md_ready  out  1  MD request accepted this cycle (combinational).
- sb_set_en  in  1  MD op issued; mark sb_set_dest pending.
- sb_set_dest  in  ADDRESS_WIDTH  register to mark pending.
- chk_addr1  in  ADDRESS_WIDTH  hazard check address (decode rs1).
- chk_addr2  in  ADDRESS_WIDTH  hazard check address (decode rs2).
- chk_busy1  out  1  pending[chk_addr1] (combinational).
- chk_busy2  out  1  pending[chk_addr2] (combinational).
- sb_overlap  out  1  sticky error: sb_set_en hit an already-pending register.
- rg_wrt_en  out  1  registered write enable to RegFile.
- rg_wrt_dest  out  ADDRESS_WIDTH  registered write address.
- rg_wrt_data  out  DATA_WIDTH  registered write data.

Behaviour:
- Reset (rst=0, asynchronous):
  - rg_wrt_en/dest/data = 0; sb_overlap = 0.
  - All pending bits = 0; state = PRI_WB; starve counter = 0.
  - A granted write not yet registered is dropped.
- Handshake: a transfer occurs when valid && ready. At most one transfer per cycle.
- State PRI_WB:
  - wb_ready = 1.
  - md_ready = md_valid && !wb_valid.
- State PRI_MD:
  - md_ready = 1.
  - wb_ready = !md_valid.
- Ready does not depend on dest.
- Starve counter (width clog2(STARVE_LIMIT+1)):
  - Increments each cycle md_valid && !md_ready, saturating.
  - Cleared on any MD transfer or when md_valid = 0.
- Transitions:
  - PRI_WB -> PRI_MD when the counter reaches STARVE_LIMIT (counter == STARVE_LIMIT after the edge).
  - PRI_MD -> PRI_WB after one MD transfer, or if md_valid = 0 in PRI_MD.
- Output stage, latency 1:
  - On the edge ending a transfer cycle: rg_wrt_en = 1 and dest/data are copied from the winner.
  - With no transfer: rg_wrt_en = 0, and dest/data hold their previous values.
  - A transfer with dest = 0 is accepted but produces rg_wrt_en = 0.
- Scoreboard, pending[NUM_REGS]:
  - Set on sb_set_en when sb_set_dest != 0.
  - Cleared on the edge ending an MD transfer with md_dest != 0, the same edge rg_wrt_en rises.
  - RegFile commits at the following negedge, so a stalled reader sees valid data by the next posedge.
  - Same-cycle set and clear of the same register: set wins.
  - sb_set_en on an already-pending register: bit stays 1 and sb_overlap latches 1 until reset.
  - pending[0] is always 0.
- WB writes never touch the scoreboard.
- chk_busy reflects the registered pending bits only; there is no forwarding of in-flight data.
- Simultaneous WB and MD requests:
  - In PRI_WB, WB wins and MD stalls.
  - After STARVE_LIMIT consecutive stalls, MD wins exactly once.

Decomposition:
- Package rf_ctrl_pkg:
  - arb_state_t enum {PRI_WB, PRI_MD}.
  - Default width constants (DATA_WIDTH, ADDRESS_WIDTH, NUM_REGS).
  - STARVE_LIMIT default.
- Sub-module rf_scoreboard:
  - Contents: the pending vector, set/clear priority, x0 masking, sb_overlap, and the two combinational busy lookups.
  - Parameterised by ADDRESS_WIDTH and NUM_REGS.
- Arbiter FSM, starve counter and output register stay in rf_wb_arbiter.

Test Plan:
- Reset then idle → all outputs 0, chk_busy1/2 = 0 for every address.
- Single MD write to x5:
  - Stimulus: sb_set_en with dest 5; 3 cycles later md_valid with dest 5, data 0xDEADBEEF.
  - Response: chk_busy1 = 1 (chk_addr1=5) until the grant edge; then rg_wrt_en = 1, dest 5, data 0xDEADBEEF for 1 cycle, and busy clears on that same edge.
- Contention:
  - Stimulus: wb_valid and md_valid held 1 continuously.
  - Response: WB granted 4 cycles, MD granted on the 5th, pattern repeats.
  - Check: rg_wrt_dest alternates accordingly, one cycle behind each grant.
- x0 handling:
  - WB write to dest 0 → wb_ready = 1, rg_wrt_en stays 0.
  - sb_set_en dest 0 → chk_busy for address 0 stays 0.
- Overlap and same-cycle set/clear:
  - sb_set x7 twice → sb_overlap = 1, sticky.
  - MD write x7 with sb_set x7 in the same cycle → x7 remains busy.
- Asynchronous reset mid-operation:
  - Stimulus: drop rst between clock edges during a pending MD grant.
  - Response: outputs clear immediately, no write issued, scoreboard cleared, state returns to PRI_WB.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared types and default sizing for the register-file write-port control slice.
package rf_ctrl_pkg;

  typedef enum logic {
    PRI_WB,
    PRI_MD
  } arb_state_t;

  localparam int RF_DATA_WIDTH    = 32;
  localparam int RF_ADDRESS_WIDTH = 5;
  localparam int RF_NUM_REGS      = 32;
  localparam int RF_STARVE_LIMIT  = 4;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Per-register pending scoreboard for multi-cycle results, with x0 masking,
// set-over-clear priority and a sticky double-issue flag.
module rf_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
  parameter int NUM_REGS      = RF_NUM_REGS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [ADDRESS_WIDTH-1:0] set_dest,
  input  logic                     clr_en,
  input  logic [ADDRESS_WIDTH-1:0] clr_dest,
  input  logic [ADDRESS_WIDTH-1:0] chk_addr1,
  input  logic [ADDRESS_WIDTH-1:0] chk_addr2,
  output logic                     chk_busy1,
  output logic                     chk_busy2,
  output logic                     sb_overlap
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;
  logic                overlap_hit;

  // Clear is applied before set so a reissue to the retiring register stays pending.
  always_comb begin
    pending_next = pending;
    overlap_hit  = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (clr_en && (clr_dest == ADDRESS_WIDTH'(i))) begin
        pending_next[i] = 1'b0;
      end
      if (set_en && (set_dest == ADDRESS_WIDTH'(i))) begin
        pending_next[i] = 1'b1;
        if (pending[i]) begin
          overlap_hit = 1'b1;
        end
      end
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= '0;
      sb_overlap <= 1'b0;
    end else begin
      pending <= pending_next;
      if (overlap_hit) begin
        sb_overlap <= 1'b1;
      end
    end
  end

  always_comb begin
    chk_busy1 = 1'b0;
    chk_busy2 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (chk_addr1 == ADDRESS_WIDTH'(i)) begin
        chk_busy1 = pending[i];
      end
      if (chk_addr2 == ADDRESS_WIDTH'(i)) begin
        chk_busy2 = pending[i];
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between in-order writeback and the
// mul/div unit, with anti-starvation priority and a registered write stage.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
  parameter int NUM_REGS      = RF_NUM_REGS,
  parameter int STARVE_LIMIT  = RF_STARVE_LIMIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [ADDRESS_WIDTH-1:0] wb_dest,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     wb_ready,
  input  logic                     md_valid,
  input  logic [ADDRESS_WIDTH-1:0] md_dest,
  input  logic [DATA_WIDTH-1:0]    md_data,
  output logic                     md_ready,
  input  logic                     sb_set_en,
  input  logic [ADDRESS_WIDTH-1:0] sb_set_dest,
  input  logic [ADDRESS_WIDTH-1:0] chk_addr1,
  input  logic [ADDRESS_WIDTH-1:0] chk_addr2,
  output logic                     chk_busy1,
  output logic                     chk_busy2,
  output logic                     sb_overlap,
  output logic                     rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             wb_xfer;
  logic             md_xfer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PRI_WB;
    end else begin
      state <= state_next;
    end
  end

  // MD holds priority for a single grant, or until it withdraws its request.
  always_comb begin
    state_next = state;
    case (state)
      PRI_WB: if (starve_cnt_next == CNT_MAX) state_next = PRI_MD;
      PRI_MD: if (md_xfer || !md_valid) state_next = PRI_WB;
      default: state_next = PRI_WB;
    endcase
  end

  always_comb begin
    wb_ready = 1'b0;
    md_ready = 1'b0;
    case (state)
      PRI_WB: begin
        wb_ready = 1'b1;
        md_ready = md_valid && !wb_valid;
      end
      PRI_MD: begin
        md_ready = 1'b1;
        wb_ready = !md_valid;
      end
      default: begin
        wb_ready = 1'b0;
        md_ready = 1'b0;
      end
    endcase
  end

  assign wb_xfer = wb_valid && wb_ready;
  assign md_xfer = md_valid && md_ready;

  always_comb begin
    if (!md_valid || md_xfer) begin
      starve_cnt_next = '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt_next = starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt_next = starve_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_next;
    end
  end

  // Writes to x0 are accepted and consumed but never reach the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rg_wrt_en   <= 1'b0;
      rg_wrt_dest <= '0;
      rg_wrt_data <= '0;
    end else if (wb_xfer) begin
      rg_wrt_en   <= (wb_dest != '0);
      rg_wrt_dest <= wb_dest;
      rg_wrt_data <= wb_data;
    end else if (md_xfer) begin
      rg_wrt_en   <= (md_dest != '0);
      rg_wrt_dest <= md_dest;
      rg_wrt_data <= md_data;
    end else begin
      rg_wrt_en <= 1'b0;
    end
  end

  rf_scoreboard #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_REGS     (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (sb_set_en),
    .set_dest  (sb_set_dest),
    .clr_en    (md_xfer),
    .clr_dest  (md_dest),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .sb_overlap(sb_overlap)
  );

endmodule
